// File: rtl/mstage_bus.sv
// EX->MEM pipeline boundary register with a two-entry skid buffer.
// s_ready is taken straight from a register; a synchronous flush drops both entries.
module mstage_bus #(
   parameter logic [31:0] RESET_PC = 32'h80000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,

   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] aluresX,
   input  logic [31:0] src2X,
   input  logic [31:0] pcX,
   input  logic [31:0] snpcX,
   input  logic [31:0] csrX,
   input  logic [11:0] csraddrX,
   input  logic [7:0]  mwmaskX,
   input  logic [2:0]  mrtypeX,
   input  logic [2:0]  rdregsrcX,
   input  logic [4:0]  rdX,
   input  logic        mvalidX,
   input  logic        mwenX,
   input  logic        ecallX,
   input  logic        mretX,

   output logic [31:0] aluresM,
   output logic [31:0] src2M,
   output logic [31:0] pcM,
   output logic [31:0] snpcM,
   output logic [31:0] csrM,
   output logic [11:0] csraddrM,
   output logic [7:0]  mwmaskM,
   output logic [2:0]  mrtypeM,
   output logic [2:0]  rdregsrcM,
   output logic [4:0]  rdM,
   output logic        mvalidM,
   output logic        mwenM,
   output logic        ecallM,
   output logic        mretM,
   output logic        m_valid,
   input  logic        m_ready
);

   typedef struct packed {
      logic [31:0] alures;
      logic [31:0] src2;
      logic [31:0] pc;
      logic [31:0] snpc;
      logic [31:0] csr;
      logic [11:0] csraddr;
      logic [7:0]  mwmask;
      logic [2:0]  mrtype;
      logic [2:0]  rdregsrc;
      logic [4:0]  rd;
      logic        mvalid;
      logic        mwen;
      logic        ecall;
      logic        mret;
   } beat_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   state_t state, state_next;
   beat_t  in_beat, out_q, sk_q;
   logic   out_v, sk_v;
   logic   accept, drain;
   logic   load_out, load_sk, out_from_sk;

   assign in_beat = '{
      alures:   aluresX,
      src2:     src2X,
      pc:       pcX,
      snpc:     snpcX,
      csr:      csrX,
      csraddr:  csraddrX,
      mwmask:   mwmaskX,
      mrtype:   mrtypeX,
      rdregsrc: rdregsrcX,
      rd:       rdX,
      mvalid:   mvalidX,
      mwen:     mwenX,
      ecall:    ecallX,
      mret:     mretX
   };

   // The (sk_v & !out_v) combination has no encoding, so it cannot arise.
   assign out_v   = (state != EMPTY);
   assign sk_v    = (state == FULL);
   assign s_ready = !sk_v;
   assign m_valid = out_v;
   assign accept  = s_valid & s_ready;
   assign drain   = m_valid & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Flush overrides everything; any beat offered alongside it is discarded.
   always_comb begin
      state_next  = state;
      load_out    = 1'b0;
      load_sk     = 1'b0;
      out_from_sk = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_out   = 1'b1;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_out   = 1'b1;
               end else if (accept) begin
                  load_sk    = 1'b1;
                  state_next = FULL;
               end else if (drain) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  out_from_sk = 1'b1;
                  state_next  = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q      <= '0;
         out_q.pc   <= RESET_PC;
         out_q.snpc <= RESET_PC;
         sk_q       <= '0;
         sk_q.pc    <= RESET_PC;
         sk_q.snpc  <= RESET_PC;
      end else begin
         if (load_out) begin
            out_q <= in_beat;
         end else if (out_from_sk) begin
            out_q <= sk_q;
         end
         if (load_sk) begin
            sk_q <= in_beat;
         end
      end
   end

   assign aluresM   = out_q.alures;
   assign src2M     = out_q.src2;
   assign pcM       = out_q.pc;
   assign snpcM     = out_q.snpc;
   assign csrM      = out_q.csr;
   assign csraddrM  = out_q.csraddr;
   assign mwmaskM   = out_q.mwmask;
   assign mrtypeM   = out_q.mrtype;
   assign rdregsrcM = out_q.rdregsrc;
   assign rdM       = out_q.rd;

   // A bubble must never write memory or trap.
   assign mvalidM = out_q.mvalid & out_v;
   assign mwenM   = out_q.mwen   & out_v;
   assign ecallM  = out_q.ecall  & out_v;
   assign mretM   = out_q.mret   & out_v;

endmodule

// File: tb/tb_mstage_bus.sv
// Directed-vector and scoreboard bench for mstage_bus.
// Table vectors cover handshake, skid and flush; hand sequences cover reset, streaming and random traffic.
module tb_mstage_bus;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] aluresX, src2X, pcX, snpcX, csrX;
   logic [11:0] csraddrX;
   logic [7:0]  mwmaskX;
   logic [2:0]  mrtypeX, rdregsrcX;
   logic [4:0]  rdX;
   logic        mvalidX, mwenX, ecallX, mretX;
   logic [31:0] aluresM, src2M, pcM, snpcM, csrM;
   logic [11:0] csraddrM;
   logic [7:0]  mwmaskM;
   logic [2:0]  mrtypeM, rdregsrcM;
   logic [4:0]  rdM;
   logic        mvalidM, mwenM, ecallM, mretM;
   logic        m_valid;
   logic        m_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mstage_bus dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready),
      .aluresX(aluresX), .src2X(src2X), .pcX(pcX), .snpcX(snpcX), .csrX(csrX),
      .csraddrX(csraddrX), .mwmaskX(mwmaskX), .mrtypeX(mrtypeX), .rdregsrcX(rdregsrcX),
      .rdX(rdX), .mvalidX(mvalidX), .mwenX(mwenX), .ecallX(ecallX), .mretX(mretX),
      .aluresM(aluresM), .src2M(src2M), .pcM(pcM), .snpcM(snpcM), .csrM(csrM),
      .csraddrM(csraddrM), .mwmaskM(mwmaskM), .mrtypeM(mrtypeM), .rdregsrcM(rdregsrcM),
      .rdM(rdM), .mvalidM(mvalidM), .mwenM(mwenM), .ecallM(ecallM), .mretM(mretM),
      .m_valid(m_valid), .m_ready(m_ready)
   );

   typedef struct {
      logic        sv;
      logic        mr;
      logic        fl;
      logic [31:0] pc;
      logic [31:0] alu;
      logic        mwen;
      logic        e_mv;
      logic        e_sr;
      logic [31:0] e_pc;
      logic [31:0] e_alu;
      logic        e_mwen;
   } vec_t;

   vec_t vecs[15];

   task automatic applyStimulus(input logic sv, input logic mr, input logic fl,
                                input logic [31:0] pc, input logic [31:0] alu, input logic mwen);
      s_valid   = sv;
      m_ready   = mr;
      flush     = fl;
      pcX       = pc;
      snpcX     = pc + 32'd4;
      aluresX   = alu;
      src2X     = alu ^ 32'hFFFF0000;
      csrX      = 32'h0;
      csraddrX  = 12'h0;
      mwmaskX   = 8'h0F;
      mrtypeX   = 3'd2;
      rdregsrcX = 3'd1;
      rdX       = alu[4:0];
      mvalidX   = mwen;
      mwenX     = mwen;
      ecallX    = 1'b0;
      mretX     = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   logic [31:0] q[$];
   logic [31:0] seq;
   logic [31:0] exp_v;
   int          beats;
   int          cycles;

   initial begin
      //               sv    mr    fl    pc            alu           mwen  e_mv  e_sr  e_pc          e_alu         e_mwen
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h80000010, 32'h00001234, 1'b1, 1'b1, 1'b1, 32'h80000010, 32'h00001234, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h80000010, 32'h00001234, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h00000100, 32'h0000000A, 1'b1, 1'b1, 1'b1, 32'h00000100, 32'h0000000A, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h00000104, 32'h0000000B, 1'b0, 1'b1, 1'b0, 32'h00000100, 32'h0000000A, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h00000108, 32'h0000000C, 1'b1, 1'b1, 1'b0, 32'h00000100, 32'h0000000A, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h00000108, 32'h0000000C, 1'b1, 1'b1, 1'b1, 32'h00000104, 32'h0000000B, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h00000108, 32'h0000000C, 1'b1, 1'b1, 1'b1, 32'h00000108, 32'h0000000C, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000108, 32'h0000000C, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h00000200, 32'h000000D0, 1'b1, 1'b1, 1'b1, 32'h00000200, 32'h000000D0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h00000204, 32'h000000D1, 1'b0, 1'b1, 1'b0, 32'h00000200, 32'h000000D0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h00000208, 32'h000000D2, 1'b1, 1'b0, 1'b1, 32'h00000200, 32'h000000D0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000200, 32'h000000D0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h00000300, 32'h000000E0, 1'b1, 1'b1, 1'b1, 32'h00000300, 32'h000000E0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h00000304, 32'h000000E1, 1'b1, 1'b0, 1'b1, 32'h00000300, 32'h000000E0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000300, 32'h000000E0, 1'b0};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #12;
      checkOutput("reset m_valid", {31'b0, m_valid}, 32'd0);
      checkOutput("reset s_ready", {31'b0, s_ready}, 32'd1);
      checkOutput("reset pcM", pcM, 32'h80000000);
      checkOutput("reset snpcM", snpcM, 32'h80000000);
      checkOutput("reset aluresM", aluresM, 32'h0);
      checkOutput("reset rdM", {27'b0, rdM}, 32'h0);
      checkOutput("reset mwenM", {31'b0, mwenM}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].sv, vecs[i].mr, vecs[i].fl, vecs[i].pc, vecs[i].alu, vecs[i].mwen);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d m_valid", i), {31'b0, m_valid}, {31'b0, vecs[i].e_mv});
         checkOutput($sformatf("v%0d s_ready", i), {31'b0, s_ready}, {31'b0, vecs[i].e_sr});
         checkOutput($sformatf("v%0d pcM", i), pcM, vecs[i].e_pc);
         checkOutput($sformatf("v%0d aluresM", i), aluresM, vecs[i].e_alu);
         checkOutput($sformatf("v%0d mwenM", i), {31'b0, mwenM}, {31'b0, vecs[i].e_mwen});
      end

      // Fill both entries, then reset between edges.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h500, 32'h50, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h504, 32'h51, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("full s_ready", {31'b0, s_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async m_valid", {31'b0, m_valid}, 32'd0);
      checkOutput("async s_ready", {31'b0, s_ready}, 32'd1);
      checkOutput("async pcM", pcM, 32'h80000000);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h600, 32'h60, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("post-reset m_valid", {31'b0, m_valid}, 32'd1);
      checkOutput("post-reset pcM", pcM, 32'h600);
      checkOutput("post-reset aluresM", aluresM, 32'h60);

      // Back-to-back stream with the consumer always ready.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h80000000 + 32'(4 * k), 32'(k), 1'b1);
         @(posedge clk);
         #1;
         checkOutput($sformatf("stream%0d m_valid", k), {31'b0, m_valid}, 32'd1);
         checkOutput($sformatf("stream%0d s_ready", k), {31'b0, s_ready}, 32'd1);
         checkOutput($sformatf("stream%0d pcM", k), pcM, 32'h80000000 + 32'(4 * k));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("stream end m_valid", {31'b0, m_valid}, 32'd0);

      // Random handshakes against an in-order scoreboard.
      seq    = 32'd1;
      beats  = 0;
      cycles = 0;
      while (beats < 10000 && cycles < 40000) begin
         applyStimulus(($urandom_range(3) != 0), ($urandom_range(3) != 0), 1'b0, seq, seq, 1'b1);
         #3;
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               checkOutput("rnd unexpected beat", aluresM, 32'hFFFFFFFF);
            end else begin
               exp_v = q.pop_front();
               checkOutput("rnd aluresM", aluresM, exp_v);
               checkOutput("rnd rdM", {27'b0, rdM}, {27'b0, exp_v[4:0]});
               checkOutput("rnd mwenM", {31'b0, mwenM}, 32'd1);
            end
         end
         if (!m_valid) begin
            checkOutput("rnd bubble mwenM", {31'b0, mwenM}, 32'd0);
         end
         if (s_valid && s_ready) begin
            q.push_back(seq);
            seq++;
            beats++;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("rnd beats", 32'(beats), 32'd10000);

      cycles = 0;
      while (q.size() > 0 && cycles < 10) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
         #3;
         if (m_valid) begin
            exp_v = q.pop_front();
            checkOutput("rnd tail aluresM", aluresM, exp_v);
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("rnd leftover", 32'(q.size()), 32'd0);
      checkOutput("rnd final m_valid", {31'b0, m_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
